// File: rtl/q2fsm_pkg.sv
// Shared types and helpers for the time-multiplexed sequence-detector scheduler.
package q2fsm_pkg;

    // Detector states; codes 6 and 7 are never produced and read back as A.
    typedef enum logic [2:0] {
        ST_A = 3'd0,
        ST_B = 3'd1,
        ST_C = 3'd2,
        ST_D = 3'd3,
        ST_E = 3'd4,
        ST_F = 3'd5
    } state_t;

    localparam state_t ST_RESET = ST_A;

    // Detect flag is a pure function of the state just entered.
    function automatic logic is_detect(input state_t s);
        return (s == ST_E) || (s == ST_F);
    endfunction

endpackage

// File: rtl/q2fsm_step.sv
// Combinational single-step of the six-state detector, shared across channels.
module q2fsm_step
    import q2fsm_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic       w_i,
    output state_t     next_o,
    output logic       z_o
);

    // Next-state table; illegal codes behave exactly like A.
    always_comb begin
        next_o = ST_A;
        case (state_i)
            ST_A:    next_o = w_i ? ST_B : ST_A;
            ST_B:    next_o = w_i ? ST_C : ST_D;
            ST_C:    next_o = w_i ? ST_E : ST_D;
            ST_D:    next_o = w_i ? ST_F : ST_A;
            ST_E:    next_o = w_i ? ST_E : ST_D;
            ST_F:    next_o = w_i ? ST_C : ST_D;
            default: next_o = w_i ? ST_B : ST_A;
        endcase
        z_o = is_detect(next_o);
    end

endmodule

// File: rtl/q2fsm_ctx_sched.sv
// Round-robin scheduler sharing one detector step engine across NCH channel contexts.
module q2fsm_ctx_sched
    import q2fsm_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] in_valid,
    input  logic [NCH-1:0] in_w,
    output logic [NCH-1:0] in_ready,
    input  logic [NCH-1:0] clear,
    output logic           out_valid,
    output logic [CW-1:0]  out_ch,
    output logic           out_z,
    output logic [2:0]     out_state
);

    state_t          ctx_q [NCH];
    state_t          ctx_d [NCH];
    logic [CW-1:0]   ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_ch_q, out_ch_d;
    logic            out_z_q, out_z_d;
    state_t          out_state_q, out_state_d;

    logic            grant_vld;
    logic [CW-1:0]   grant_idx;
    logic [CW:0]     scan_idx;
    logic [2:0]      step_cur;
    state_t          step_next;
    logic            step_z;

    // Search from ptr upward with wrap; first requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NCH; i++) begin
            scan_idx = {1'b0, ptr_q} + (CW+1)'(i);
            if (scan_idx >= (CW+1)'(NCH)) scan_idx = scan_idx - (CW+1)'(NCH);
            if (!grant_vld && in_valid[scan_idx[CW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[CW-1:0];
            end
        end
    end

    // One-hot grant, all-zero when nobody requests.
    always_comb begin
        in_ready = '0;
        if (grant_vld) in_ready[grant_idx] = 1'b1;
    end

    // A same-cycle clear makes the consumed bit step from A.
    assign step_cur = clear[grant_idx] ? ST_RESET : ctx_q[grant_idx];

    q2fsm_step u_step (
        .state_i (step_cur),
        .w_i     (in_w[grant_idx]),
        .next_o  (step_next),
        .z_o     (step_z)
    );

    // Context, pointer and result-register next values.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ctx_d[c] = ctx_q[c];
            if (clear[c]) ctx_d[c] = ST_RESET;
            if (grant_vld && (grant_idx == CW'(c))) ctx_d[c] = step_next;
        end
        ptr_d       = ptr_q;
        out_valid_d = grant_vld;
        out_ch_d    = out_ch_q;
        out_z_d     = out_z_q;
        out_state_d = out_state_q;
        if (grant_vld) begin
            ptr_d       = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + 1'b1;
            out_ch_d    = grant_idx;
            out_z_d     = step_z;
            out_state_d = step_next;
        end
    end

    // State registers; reset dominates clear and grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) ctx_q[c] <= ST_RESET;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_z_q     <= 1'b0;
            out_state_q <= ST_RESET;
        end else begin
            for (int c = 0; c < NCH; c++) ctx_q[c] <= ctx_d[c];
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_z_q     <= out_z_d;
            out_state_q <= out_state_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_z     = out_z_q;
    assign out_state = out_state_q;

endmodule

// File: tb/tb_q2fsm_ctx_sched.sv
// Table-driven, scoreboard-checked bench for q2fsm_ctx_sched with NCH=4.
module tb_q2fsm_ctx_sched;

    localparam logic [2:0] SA = 3'd0, SB = 3'd1, SC = 3'd2, SD = 3'd3, SE = 3'd4, SF = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_valid, in_w, in_ready, clear;
    logic       out_valid, out_z;
    logic [1:0] out_ch;
    logic [2:0] out_state;

    q2fsm_ctx_sched #(.NCH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_w      (in_w),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_z     (out_z),
        .out_state (out_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic [3:0] w;
        logic [3:0] clr;
        logic [3:0] rdy;
        logic [1:0] ch;
        logic [2:0] st;
        logic       z;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [2:0] st;
        logic       z;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void addv(input logic r, input logic [3:0] v, input logic [3:0] w,
                                 input logic [3:0] c, input logic [3:0] rd,
                                 input logic [1:0] ch, input logic [2:0] st, input logic z);
        vec_t t;
        t.rst = r; t.vld = v; t.w = w; t.clr = c; t.rdy = rd; t.ch = ch; t.st = st; t.z = z;
        tbl.push_back(t);
    endfunction

    // Compare registered outputs against the scoreboard head (or hold when none due).
    task automatic check_outputs(input string tag);
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " out_ch"},    32'(out_ch),    32'(e.ch));
            chk({tag, " out_state"}, 32'(out_state), 32'(e.st));
            chk({tag, " out_z"},     32'(out_z),     32'(e.z));
            last = e;
        end else begin
            chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
            chk({tag, " hold out_ch"},    32'(out_ch),    32'(last.ch));
            chk({tag, " hold out_state"}, 32'(out_state), 32'(last.st));
            chk({tag, " hold out_z"},     32'(out_z),     32'(last.z));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = '0; in_w = '0; clear = '0;
        @(posedge clk);
        #1;
        sb.delete();
        last = '{ch: 2'd0, st: SA, z: 1'b0};
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        string tag;
        tag = $sformatf("row%0d", idx);
        if (t.rst) do_reset();
        @(negedge clk);
        in_valid = t.vld; in_w = t.w; clear = t.clr;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(t.rdy));
        @(posedge clk);
        if (t.rdy != 4'b0000) begin
            e.ch = t.ch; e.st = t.st; e.z = t.z;
            sb.push_back(e);
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_w = '0; clear = '0;
        last = '{ch: 2'd0, st: SA, z: 1'b0};

        // Reset state and arbitration from ptr = 0.
        do_reset();
        chk("rst out_ch", 32'(out_ch), 32'd0);
        chk("rst out_state", 32'(out_state), 32'd0);
        chk("rst ready idle", 32'(in_ready), 32'd0);
        in_valid = 4'b1111; #1;
        chk("rst ready all", 32'(in_ready), 32'b0001);
        in_valid = 4'b1010; #1;
        chk("rst ready 1010", 32'(in_ready), 32'b0010);
        in_valid = 4'b0000;

        // ch0 stream 1,1,0,1
        addv(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, SB, 0);
        addv(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, SC, 0);
        addv(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, SD, 0);
        addv(0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 2'd0, SF, 1);
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, SA, 0);
        // ch2 stream 1,1,1,1,0
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SB, 0);
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SC, 0);
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SE, 1);
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SE, 1);
        addv(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, SD, 0);
        // All requesting from ptr = 0: ch0/ch2 see 1s, ch1/ch3 see 0s.
        addv(1, 4'b1111, 4'b0101, 4'b0000, 4'b0001, 2'd0, SB, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0010, 2'd1, SA, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0100, 2'd2, SB, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b1000, 2'd3, SA, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0001, 2'd0, SC, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0010, 2'd1, SA, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0100, 2'd2, SC, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b1000, 2'd3, SA, 0);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0001, 2'd0, SE, 1);
        addv(0, 4'b1111, 4'b0101, 4'b0000, 4'b0010, 2'd1, SA, 0);
        // ch1 to E, then clear together with an accepted 1.
        addv(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, SB, 0);
        addv(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, SC, 0);
        addv(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 2'd1, SE, 1);
        addv(0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 2'd1, SB, 0);
        // Clear alone on ch0 (at E), then a 0 on ch0 must step from A.
        addv(0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 2'd0, SA, 0);
        addv(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, SA, 0);
        // ch2 (at C) sole requester for three cycles, then idle.
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SE, 1);
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SE, 1);
        addv(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, SE, 1);
        addv(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, SA, 0);
        // Drive ch3 to F ahead of the mid-operation reset.
        addv(1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, SB, 0);
        addv(0, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, SD, 0);
        addv(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 2'd3, SF, 1);

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while a ch3 grant is pending: result discarded, ctx and ptr cleared.
        @(negedge clk);
        reset = 1'b1; in_valid = 4'b1000; in_w = 4'b0000;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_state", 32'(out_state), 32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 4'b1111;
        #1;
        chk("midrst ptr0 ready", 32'(in_ready), 32'b0001);
        in_valid = 4'b1000; in_w = 4'b0000;
        #1;
        chk("midrst ch3 ready", 32'(in_ready), 32'b1000);
        @(posedge clk);
        sb.push_back('{ch: 2'd3, st: SA, z: 1'b0});
        #1;
        check_outputs("midrst ch3");
        @(negedge clk);
        in_valid = '0;
        @(posedge clk);
        #1;
        check_outputs("midrst idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
